// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and the instruction field parser.
//   PC_WIDTH      : program counter width (RV64 byte address)
//   RESET_PC      : word-aligned PC loaded on reset
//   NOP_WORD      : addi x0,x0,0, returned for addresses past the memory
//   fetch_state_e : fetch FSM states
//   instr_word_t  : one 32-bit instruction word
package fetch_pkg;

  localparam int          PC_WIDTH = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

  typedef logic [31:0] instr_word_t;

endpackage

// File: rtl/imem_sync.sv
// Word-organised instruction memory with one write port and one synchronous
// read port (1-cycle latency).
//   clk_i   : clock
//   we_i    : write enable; waddr_i / wdata_i : word index / data to write
//   re_i    : read enable; raddr_i : byte address to read
//   rdata_o : read data, valid the cycle after re_i
// A read and a write to the same word in one cycle return the old word.
// Byte addresses at or beyond 4*DEPTH read back as NOP.
module imem_sync import fetch_pkg::*; #(
  parameter int          DEPTH  = 64,
  parameter int          ADDR_W = 64,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  instr_word_t              wdata_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output instr_word_t              rdata_o
);

  localparam int IDX_W = $clog2(DEPTH);

  instr_word_t mem_q [DEPTH];
  instr_word_t rdata_q;
  logic        out_of_range;
  logic        unused_lsb;

  // Any set bit above the word index means the address is past the array.
  assign out_of_range = |raddr_i[ADDR_W-1:IDX_W+2];
  assign unused_lsb   = ^raddr_i[1:0];

  // Both updates are non-blocking, so a same-cycle read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= out_of_range ? NOP : mem_q[raddr_i[IDX_W+1:2]];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, instruction memory and a registered
// valid/ready output feeding the instruction field parser.
//   clk, reset                : clock, synchronous active-high reset
//   imem_we/waddr/wdata       : instruction memory write port (always live)
//   branch_taken/target       : redirect pulse and byte target
//   ins_ready                 : downstream accepts the current instruction
//   ins_valid/ins_word/pc_out : registered instruction and its byte address
//   fetch_error               : sticky, set by a misaligned redirect
module instruction_fetch #(
  parameter int                  IMEM_DEPTH = 64,
  parameter int                  PC_WIDTH   = fetch_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(fetch_pkg::RESET_PC),
  parameter logic [31:0]         NOP_WORD   = fetch_pkg::NOP_WORD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  fetch_pkg::instr_word_t        imem_wdata,
  input  logic                          branch_taken,
  input  logic [PC_WIDTH-1:0]           branch_target,
  input  logic                          ins_ready,
  output logic                          ins_valid,
  output fetch_pkg::instr_word_t        ins_word,
  output logic [PC_WIDTH-1:0]           pc_out,
  output logic                          fetch_error
);

  import fetch_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rd_pc_q, rd_pc_d;   // address of the read in flight
  logic                pend_q, pend_d;     // memory read data is meaningful
  logic                valid_q, valid_d;
  instr_word_t         word_q, word_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                err_q, err_d;

  logic                rd_en;
  instr_word_t         rdata;
  logic                advance;
  logic                redirect;
  logic                misaligned;

  imem_sync #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (PC_WIDTH),
    .NOP    (NOP_WORD)
  ) u_imem (
    .clk_i   (clk),
    .we_i    (imem_we),
    .waddr_i (imem_waddr),
    .wdata_i (imem_wdata),
    .re_i    (rd_en),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  assign advance    = !valid_q || ins_ready;
  assign redirect   = (state_q == RUN) && branch_taken;
  assign misaligned = redirect && (branch_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (misaligned) state_d = ERROR;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = 1'b0;
    pc_d     = pc_q;
    rd_pc_d  = rd_pc_q;
    pend_d   = pend_q;
    valid_d  = valid_q;
    word_d   = word_q;
    pc_out_d = pc_out_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        rd_en   = 1'b1;
        rd_pc_d = pc_q;
        pc_d    = pc_q + PC_WIDTH'(4);
        pend_d  = 1'b1;
        valid_d = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          // Drop both the held output and the read in flight; the target is
          // read on the next advance.
          valid_d = 1'b0;
          pend_d  = 1'b0;
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            pc_d = branch_target;
          end
        end else if (advance) begin
          // After a redirect the first advance has no read in flight, so the
          // output stays invalid while the target read is issued.
          valid_d  = pend_q;
          word_d   = rdata;
          pc_out_d = rd_pc_q;
          rd_en    = 1'b1;
          rd_pc_d  = pc_q;
          pc_d     = pc_q + PC_WIDTH'(4);
          pend_d   = 1'b1;
        end
      end
      ERROR: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      word_q   <= '0;
      pc_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
      pc_out_q <= pc_out_d;
      err_q    <= err_d;
    end
  end

  // Only meaningful while pend_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_pc_q <= rd_pc_d;
  end

  assign ins_valid   = valid_q;
  assign ins_word    = word_q;
  assign pc_out      = pc_out_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected {pc, word} pairs are
// queued as stimulus is driven and compared on every fire.
module tb_instruction_fetch;

  localparam int          DEPTH = 64;
  localparam int          PCW   = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_we;
  logic [5:0]        imem_waddr;
  logic [31:0]       imem_wdata;
  logic              branch_taken;
  logic [PCW-1:0]    branch_target;
  logic              ins_ready;
  logic              ins_valid;
  logic [31:0]       ins_word;
  logic [PCW-1:0]    pc_out;
  logic              fetch_error;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [31:0]    word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tb_mem [DEPTH];
  logic [31:0] word_at0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;

  instruction_fetch #(
    .IMEM_DEPTH (DEPTH),
    .PC_WIDTH   (PCW),
    .RESET_PC   (64'h0),
    .NOP_WORD   (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ins_ready     (ins_ready),
    .ins_valid     (ins_valid),
    .ins_word      (ins_word),
    .pc_out        (pc_out),
    .fetch_error   (fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [PCW-1:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = (pc >= 64'(4 * DEPTH)) ? NOP : tb_mem[pc[7:2]];
    exp_q.push_back(e);
  endtask

  // Returns at the posedge where the queue has just emptied.
  task automatic drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic redirect(input logic [PCW-1:0] tgt);
    @(posedge clk); #1;
    branch_taken  = 1'b1;
    branch_target = tgt;
    @(posedge clk); #1;
    branch_taken  = 1'b0;
  endtask

  // Fire monitor: sampled mid-cycle, the transfer happens at the next edge.
  always @(negedge clk) begin
    if (!reset && ins_valid && ins_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_fire_pc", pc_out, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("fire_pc", pc_out, e.pc);
        check_val("fire_word", 64'(ins_word), 64'(e.word));
        if (pc_out == 64'h0 && e.pc == 64'h0) word_at0 = ins_word;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    branch_taken = 1'b0; branch_target = '0; ins_ready = 1'b0;
    word_at0 = '0;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'hA500_0000 | (i << 8) | i;
    tb_mem[0] = 32'hFE0F8F80; tb_mem[1] = 32'h00500093;
    tb_mem[2] = 32'h00A00113; tb_mem[3] = 32'h002081B3;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", 64'(ins_valid), 64'd0);
    check_val("rst_word", 64'(ins_word), 64'd0);
    check_val("rst_pc_out", pc_out, 64'd0);
    check_val("rst_err", 64'(fetch_error), 64'd0);

    // Memory load while reset is held
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = tb_mem[i];
    end
    @(posedge clk); #1;
    imem_we = 1'b0;

    // Straight-line fetch: 2 edges to first valid, then one per cycle
    push_exp(0); push_exp(4); push_exp(8); push_exp(12);
    reset = 1'b0; ins_ready = 1'b1;
    drain(30, cyc);
    check_val("straight_cycles", 64'(cyc), 64'd6);
    #1 ins_ready = 1'b0;
    check_val("slice_funct7", 64'(word_at0[31:25]), 64'd127);
    check_val("slice_rs2", 64'(word_at0[24:20]), 64'd0);
    check_val("slice_rs1", 64'(word_at0[19:15]), 64'd31);
    check_val("slice_funct3", 64'(word_at0[14:12]), 64'd0);
    check_val("slice_rd", 64'(word_at0[11:7]), 64'd31);
    check_val("slice_opcode", 64'(word_at0[6:0]), 64'd0);

    // Reset mid-stall
    @(negedge clk);
    check_val("stall_pre_rst_valid", 64'(ins_valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midstall_rst_valid", 64'(ins_valid), 64'd0);
    @(posedge clk); #1;
    push_exp(0);
    reset = 1'b0; ins_ready = 1'b1;
    drain(30, cyc);
    check_val("restart_cycles", 64'(cyc), 64'd3);
    #1 ins_ready = 1'b0;

    // Backpressure: pc 4 held stable for 3 cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_valid", 64'(ins_valid), 64'd1);
      check_val("bp_pc", pc_out, 64'd4);
      check_val("bp_word", 64'(ins_word), 64'(tb_mem[1]));
      @(posedge clk);
    end
    #1;
    push_exp(4);
    ins_ready = 1'b1;
    drain(30, cyc);
    #1 ins_ready = 1'b0;
    @(negedge clk);
    check_val("bp_next_pc", pc_out, 64'd8);
    check_val("bp_next_word", 64'(ins_word), 64'(tb_mem[2]));

    // Redirect while pc 8 is stalled; pc 8 must never fire
    redirect(64'h20);
    @(negedge clk);
    check_val("redir_valid", 64'(ins_valid), 64'd0);
    push_exp(64'h20); push_exp(64'h24);
    ins_ready = 1'b1;
    drain(30, cyc);
    #1 ins_ready = 1'b0;

    // Out-of-range target returns NOP
    redirect(64'h100);
    push_exp(64'h100); push_exp(64'h104);
    ins_ready = 1'b1;
    drain(30, cyc);
    #1 ins_ready = 1'b0;

    // Misaligned redirect: sticky error, no output until reset
    redirect(64'h22);
    ins_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("err_flag", 64'(fetch_error), 64'd1);
      check_val("err_valid", 64'(ins_valid), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("err_cleared", 64'(fetch_error), 64'd0);
    @(posedge clk); #1;
    push_exp(0); push_exp(4);
    reset = 1'b0;
    drain(30, cyc);
    check_val("err_restart_cycles", 64'(cyc), 64'd4);
    #1 ins_ready = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
